// File: rtl/sum_mult_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sum_mult_gen
//  Description : Sums every integer i in [0, n-1] that is a multiple of m1 or
//                of m2 (run-time divisors, 0 = disabled). One iteration per
//                clock using modulo residue counters instead of a divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_mult_gen #(
    parameter int N_W   = 16,
    parameter int M_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic [M_W-1:0]   m1,
    input  logic [M_W-1:0]   m2,
    output logic [ACC_W-1:0] X,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [N_W-1:0] c_n_one = N_W'(1);
    localparam logic [M_W-1:0] c_m_one = M_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [N_W-1:0]   r_n;
    logic [M_W-1:0]   r_m1;
    logic [M_W-1:0]   r_m2;
    logic [N_W-1:0]   r_i;
    logic [M_W-1:0]   r_r1;
    logic [M_W-1:0]   r_r2;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] r_x;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;

    logic             w_accept;
    logic             w_last;
    logic             w_hit;
    logic [ACC_W:0]   w_sum;
    logic [M_W-1:0]   w_r1_nxt;
    logic [M_W-1:0]   w_r2_nxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_i == r_n);
    // A zero divisor never produces a hit, so its residue value is irrelevant.
    assign w_hit    = ((r_m1 != '0) && (r_r1 == '0)) ||
                      ((r_m2 != '0) && (r_r2 == '0));
    // Extra top bit captures the carry-out for the sticky overflow flag.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - N_W){1'b0}}, r_i};
    assign w_r1_nxt = (r_r1 == (r_m1 - c_m_one)) ? '0 : (r_r1 + c_m_one);
    assign w_r2_nxt = (r_r2 == (r_m2 - c_m_one)) ? '0 : (r_r2 + c_m_one);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, leave RUN once i reaches n
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default:             w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
            r_i        <= '0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_x        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_n    <= n;
                r_m1   <= m1;
                r_m2   <= m2;
                r_i    <= '0;
                r_r1   <= '0;
                r_r2   <= '0;
                r_acc  <= '0;
                r_ovf  <= 1'b0;
                r_busy <= 1'b1;
            end else if (r_state == S_RUN) begin
                if (w_last) begin
                    r_x        <= r_acc;
                    r_overflow <= r_ovf;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end else begin
                    if (w_hit) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                    end
                    r_i  <= r_i + c_n_one;
                    r_r1 <= w_r1_nxt;
                    r_r2 <= w_r2_nxt;
                end
            end
        end
    end

    assign X        = r_x;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
